icap_stream_writer: RTL and testbench
=====================================

ICAP_STREAM_WRITER -- requirements
Module: icap_stream_writer

Interface
REQ-001 Parameter BIT_SWAP, default 1, SHALL enable bit reversal within each byte of a word before driving I.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, SHALL set the WAIT_DONE watchdog limit in CLK cycles; range 1..2^20-1.
REQ-003 CLK  in  1  single clock for all logic.
REQ-004 RESETN  in  1  reset; the block has one clock, and reset is synchronous and active-low.
REQ-005 START  in  1  one-cycle pulse; arms one bitstream transfer; ignored unless state is IDLE, DONE or ERROR.
REQ-006 S_TDATA  in  32  bitstream word, byte-ordered as in the .bin file.
REQ-007 S_TVALID  in  1  S_TDATA valid.
REQ-008 S_TREADY  out  1  word accepted when S_TVALID and S_TREADY are both high at a CLK edge.
REQ-009 S_TLAST  in  1  marks the final word of the bitstream.
REQ-010 CSIB  out  1  active-low ICAP enable, registered.
REQ-011 I  out  32  ICAP configuration data, registered.
REQ-012 RDWRB  out  1  ICAP read/write select (0 = write), registered.
REQ-013 AVAIL  in  1  ICAP ready for access.
REQ-014 PRDONE  in  1  ICAP partial-reconfiguration complete.
REQ-015 PRERROR  in  1  ICAP partial-reconfiguration error.
REQ-016 BUSY  out  1  high in any state other than IDLE, DONE or ERROR.
REQ-017 DONE  out  1  sticky success flag.
REQ-018 ERROR  out  1  sticky failure flag.
REQ-019 ERR_CODE  out  2  01 = PRERROR, 10 = timeout, 00 = no error.
REQ-020 WORD_COUNT  out  32  number of words written to ICAP in the current transfer.

Function
REQ-021 The FSM SHALL have the states IDLE, ARM, WRITE, FLUSH, WAIT_DONE, DONE and ERROR.
REQ-022 On START in IDLE, DONE or ERROR, the block SHALL clear DONE, ERROR, ERR_CODE and WORD_COUNT, and enter ARM.
REQ-023 ARM: RDWRB SHALL be driven 0 while CSIB stays 1; the FSM SHALL enter WRITE on the next cycle with AVAIL=1.
REQ-024 WRITE: S_TREADY SHALL equal AVAIL combinationally; all other states SHALL hold S_TREADY=0, except FLUSH.
REQ-025 On acceptance, the next edge SHALL register I = swap(S_TDATA) and CSIB=0; latency is 1 cycle from accept to ICAP write.
REQ-026 In any cycle without acceptance, CSIB SHALL be 1 and I SHALL hold its last value.
REQ-027 WORD_COUNT SHALL increment on each CSIB=0 cycle and saturate at 0xFFFFFFFF.
REQ-028 The swap function SHALL map output bit (8k+j) to input bit (8k+7-j) for k=0..3, j=0..7; with BIT_SWAP=0 it is identity.
REQ-029 When AVAIL falls during WRITE, no word SHALL be accepted; the transfer SHALL resume when AVAIL returns, with no loss or duplication.
REQ-030 Accepting a word with S_TLAST=1 SHALL move the FSM to WAIT_DONE, and that word SHALL still be written the following cycle.
REQ-031 WAIT_DONE: after the final CSIB=0 cycle, the block SHALL restore RDWRB=1 while CSIB=1, and a watchdog counter SHALL run.
REQ-032 PRDONE=1 in WAIT_DONE SHALL cause DONE=1 and a transition to DONE.
REQ-033 Expiry of the watchdog after TIMEOUT_CYCLES cycles SHALL cause ERR_CODE=10 and a transition to ERROR.
REQ-034 PRERROR=1 in ARM, WRITE or WAIT_DONE SHALL set ERR_CODE=01 and block any further ICAP write; the CSIB=0 already registered for a word accepted this cycle SHALL still occur.
REQ-035 After a PRERROR, the FSM SHALL enter FLUSH if S_TLAST has not yet been accepted, otherwise ERROR.
REQ-036 FLUSH: S_TREADY SHALL be 1 and input words SHALL be discarded with CSIB=1; on accepting S_TLAST, RDWRB SHALL be set to 1 and the FSM SHALL enter ERROR with ERROR=1.
REQ-037 If PRDONE and PRERROR are high in the same cycle, PRERROR SHALL take priority.
REQ-038 START while BUSY SHALL be ignored.

Reset
REQ-039 While RESETN=0 at a CLK edge, the block SHALL set: state IDLE, CSIB=1, RDWRB=1, I=0, S_TREADY=0, BUSY=0, DONE=0, ERROR=0, ERR_CODE=00, WORD_COUNT=0, watchdog=0.
REQ-040 Reset asserted mid-transfer SHALL abort the transfer and reach the reset values at the next edge; no further CSIB=0 cycle SHALL occur.

Verification
REQ-041 START, then 4 words 0x01020304..., last word with TLAST, AVAIL=1, and PRDONE 5 cycles later -> I=0x8040C020 for the first word (BIT_SWAP=1), 4 CSIB=0 cycles, WORD_COUNT=4, DONE=1.
REQ-042 AVAIL dropped for 3 cycles mid-stream -> S_TREADY=0 for those cycles, no CSIB=0, and the word sequence on I is intact and unduplicated.
REQ-043 PRERROR at word 2 of 6 -> words 3..6 accepted but not written, WORD_COUNT=2, ERROR=1, ERR_CODE=01.
REQ-044 TIMEOUT_CYCLES=10 and PRDONE never asserted -> ERROR=1 and ERR_CODE=10 exactly 10 cycles after entering WAIT_DONE; RDWRB=1.
REQ-045 RESETN=0 during WRITE, then START -> all outputs at their reset values, then a clean new transfer with WORD_COUNT starting at 0.
REQ-046 BIT_SWAP=0 with data 0xAA995566 -> I=0xAA995566.

Source files
------------

// File: rtl/icap_stream_writer.sv
// icap_stream_writer: streams an AXI-Stream bitstream into the ICAP primitive,
// then waits for PRDONE/PRERROR with a watchdog and reports a sticky status.
module icap_stream_writer #(
    parameter bit          BIT_SWAP       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        START,
    input  logic [31:0] S_TDATA,
    input  logic        S_TVALID,
    output logic        S_TREADY,
    input  logic        S_TLAST,
    output logic        CSIB,
    output logic [31:0] I,
    output logic        RDWRB,
    input  logic        AVAIL,
    input  logic        PRDONE,
    input  logic        PRERROR,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [1:0]  ERR_CODE,
    output logic [31:0] WORD_COUNT
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WD_W   = 20;
    localparam int unsigned ERR_W  = 2;

    localparam logic [WD_W-1:0]  WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_NONE    = ERR_W'(0);
    localparam logic [ERR_W-1:0] ERR_PRERROR = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = ERR_W'(2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WRITE,
        ST_FLUSH,
        ST_WAIT_DONE,
        ST_DONE,
        ST_ERROR
    } state_e;

    state_e              state_q, state_d;
    logic                csib_q, csib_d;
    logic [DATA_W-1:0]   i_q, i_d;
    logic                rdwrb_q, rdwrb_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [DATA_W-1:0]   wc_q, wc_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                accept;

    // Reverse bit order inside each byte (ICAP expects bit-swapped .bin bytes)
    function automatic logic [DATA_W-1:0] swap_word(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = w;
        if (BIT_SWAP) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 8; j++) begin
                    r[8*k+j] = w[8*k+7-j];
                end
            end
        end
        return r;
    endfunction

    // Ready follows AVAIL while writing; flushing drains the stream unconditionally
    always_comb begin
        S_TREADY = ((state_q == ST_WRITE) && AVAIL) || (state_q == ST_FLUSH);
        accept   = S_TVALID && S_TREADY;
    end

    // Next-state and next-output computation
    always_comb begin
        state_d = state_q;
        csib_d  = 1'b1;
        i_d     = i_q;
        rdwrb_d = rdwrb_q;
        done_d  = done_q;
        error_d = error_q;
        err_d   = err_q;
        wc_d    = wc_q;
        wd_d    = wd_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                rdwrb_d = 1'b1;
                if (START) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    err_d   = ERR_NONE;
                    wc_d    = '0;
                    wd_d    = '0;
                    rdwrb_d = 1'b0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                rdwrb_d = 1'b0;
                if (PRERROR) begin
                    err_d   = ERR_PRERROR;
                    state_d = ST_FLUSH;
                end else if (AVAIL) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    csib_d = 1'b0;
                    i_d    = swap_word(S_TDATA);
                    if (S_TLAST) begin
                        wd_d    = '0;
                        state_d = ST_WAIT_DONE;
                    end
                end
                // A word accepted alongside PRERROR is still written next cycle
                if (PRERROR) begin
                    err_d = ERR_PRERROR;
                    if (accept && S_TLAST) begin
                        error_d = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (accept && S_TLAST) begin
                    rdwrb_d = 1'b1;
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end
            end
            ST_WAIT_DONE: begin
                rdwrb_d = 1'b1;
                wd_d    = wd_q + WD_W'(1);
                if (PRERROR) begin
                    err_d   = ERR_PRERROR;
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end else if (PRDONE) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (wd_q == WD_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Count every ICAP write, saturating
        if (!csib_d && (wc_q != '1)) begin
            wc_d = wc_q + DATA_W'(1);
        end

        busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            csib_q  <= 1'b1;
            i_q     <= '0;
            rdwrb_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            err_q   <= ERR_NONE;
            wc_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            csib_q  <= csib_d;
            i_q     <= i_d;
            rdwrb_q <= rdwrb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            err_q   <= err_d;
            wc_q    <= wc_d;
            wd_q    <= wd_d;
        end
    end

    assign CSIB       = csib_q;
    assign I          = i_q;
    assign RDWRB      = rdwrb_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign ERROR      = error_q;
    assign ERR_CODE   = err_q;
    assign WORD_COUNT = wc_q;

endmodule

// File: tb/tb_icap_stream_writer.sv
// tb_icap_stream_writer: directed/randomized bench for icap_stream_writer with a
// queue-based scoreboard of the words expected on the ICAP port.
module tb_icap_stream_writer;

    logic        clk = 1'b0;
    logic        resetn, start, s_tvalid, s_tlast, avail, prdone, prerror;
    logic [31:0] s_tdata;
    logic        s_tready, csib, rdwrb, busy, done, error;
    logic [31:0] i_w, word_count;
    logic [1:0]  err_code;
    logic        s_tready0, csib0, rdwrb0, busy0, done0, error0;
    logic [31:0] i_w0, word_count0;
    logic [1:0]  err_code0;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp0_q[$];
    logic [31:0] tx_q[$];
    int          n_wr = 0;
    logic [31:0] first_i = '0;
    bit          first_pend = 1'b0;
    logic [31:0] last_i0 = '0;

    always #5 clk = ~clk;

    icap_stream_writer #(.BIT_SWAP(1'b1), .TIMEOUT_CYCLES(10)) dut (
        .CLK(clk), .RESETN(resetn), .START(start), .S_TDATA(s_tdata), .S_TVALID(s_tvalid),
        .S_TREADY(s_tready), .S_TLAST(s_tlast), .CSIB(csib), .I(i_w), .RDWRB(rdwrb),
        .AVAIL(avail), .PRDONE(prdone), .PRERROR(prerror), .BUSY(busy), .DONE(done),
        .ERROR(error), .ERR_CODE(err_code), .WORD_COUNT(word_count)
    );

    icap_stream_writer #(.BIT_SWAP(1'b0), .TIMEOUT_CYCLES(10)) dut0 (
        .CLK(clk), .RESETN(resetn), .START(start), .S_TDATA(s_tdata), .S_TVALID(s_tvalid),
        .S_TREADY(s_tready0), .S_TLAST(s_tlast), .CSIB(csib0), .I(i_w0), .RDWRB(rdwrb0),
        .AVAIL(avail), .PRDONE(prdone), .PRERROR(prerror), .BUSY(busy0), .DONE(done0),
        .ERROR(error0), .ERR_CODE(err_code0), .WORD_COUNT(word_count0)
    );

    // Reference byte-wise bit reversal: reverse the whole word, then restore byte order
    function automatic logic [31:0] ref_swap(input logic [31:0] w);
        logic [31:0] rev;
        rev = {<<{w}};
        return {<<8{rev}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ICAP write must match the next expected word, in order
    always @(negedge clk) begin
        if (csib === 1'b0) begin
            n_wr++;
            chk("rdwrb_on_write", 32'(rdwrb), 32'd0);
            chk("write_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("write_data", i_w, exp_q.pop_front());
            if (first_pend) begin
                first_i    = i_w;
                first_pend = 1'b0;
            end
        end
        if (csib0 === 1'b0) begin
            chk("write_pending_noswap", 32'(exp0_q.size() != 0), 32'd1);
            if (exp0_q.size() != 0) chk("write_data_noswap", i_w0, exp0_q.pop_front());
            last_i0 = i_w0;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_wc", word_count, 32'd0);
        chk("start_done", 32'(done), 32'd0);
        chk("start_error", 32'(error), 32'd0);
        chk("start_errcode", 32'(err_code), 32'd0);
        chk("start_rdwrb", 32'(rdwrb), 32'd0);
        chk("start_csib", 32'(csib), 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_csib", 32'(csib), 32'd1);
        chk("rst_rdwrb", 32'(rdwrb), 32'd1);
        chk("rst_i", i_w, 32'd0);
        chk("rst_i_noswap", i_w0, 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_errcode", 32'(err_code), 32'd0);
        chk("rst_wc", word_count, 32'd0);
    endtask

    // Send tx_q; the first n_written words must reach ICAP one cycle after acceptance
    task automatic send(input int n_written, input int prerr_at, input int drop_at,
                        input bit mark_last);
        bit acc;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i != prerr_at && i != drop_at && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                cycle();
            end
            if (i == drop_at) begin
                avail    = 1'b0;
                s_tvalid = 1'b1;
                s_tdata  = tx_q[i];
                s_tlast  = 1'b0;
                for (int d = 0; d < 3; d++) begin
                    start = (d == 1);
                    #1;
                    chk("tready_avail_low", 32'(s_tready), 32'd0);
                    @(posedge clk);
                    #1;
                    chk("csib_avail_low", 32'(csib), 32'd1);
                end
                start = 1'b0;
                avail = 1'b1;
            end
            s_tdata  = tx_q[i];
            s_tvalid = 1'b1;
            s_tlast  = mark_last && (i == tx_q.size() - 1);
            prerror  = (i == prerr_at);
            acc      = 1'b0;
            for (int k = 0; k < 50 && !acc; k++) begin
                #1;
                acc = s_tready;
                if (acc && i < n_written) begin
                    exp_q.push_back(ref_swap(tx_q[i]));
                    exp0_q.push_back(tx_q[i]);
                end
                @(posedge clk);
                #1;
                prerror = 1'b0;
            end
            chk("accept", 32'(acc), 32'd1);
            if (i < n_written) begin
                chk("csib_write", 32'(csib), 32'd0);
                chk("i_write", i_w, ref_swap(tx_q[i]));
            end else begin
                chk("csib_discard", 32'(csib), 32'd1);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic fill_random(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back($urandom);
    endtask

    task automatic pulse_prdone();
        prdone = 1'b1;
        cycle();
        prdone = 1'b0;
    endtask

    initial begin
        int n0;
        int waited;
        resetn = 1'b0; start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        avail = 1'b1; prdone = 1'b0; prerror = 1'b0;
        cycle();
        cycle();
        chk_reset_vals();
        resetn = 1'b1;
        cycle();

        // Basic four-word transfer, bit-swapped, PRDONE five cycles after the last word
        tx_q = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        first_pend = 1'b1;
        n0 = n_wr;
        do_start();
        send(4, -1, -1, 1'b1);
        repeat (4) cycle();
        pulse_prdone();
        chk("t1_first_i", first_i, 32'h8040C020);
        chk("t1_writes", 32'(n_wr - n0), 32'd4);
        chk("t1_wc", word_count, 32'd4);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_rdwrb", 32'(rdwrb), 32'd1);
        chk("t1_drained", 32'(exp_q.size()), 32'd0);

        // AVAIL drops for three cycles mid-stream; START during it is ignored
        fill_random(8);
        do_start();
        send(8, -1, 3, 1'b1);
        chk("t2_wc", word_count, 32'd8);
        pulse_prdone();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_drained", 32'(exp_q.size()), 32'd0);

        // PRERROR while word 2 of 6 is accepted: the rest are flushed
        fill_random(6);
        do_start();
        send(2, 1, -1, 1'b1);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_errcode", 32'(err_code), 32'd1);
        chk("t3_wc", word_count, 32'd2);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_rdwrb", 32'(rdwrb), 32'd1);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // Watchdog expiry with no PRDONE
        fill_random(3);
        do_start();
        send(3, -1, -1, 1'b1);
        waited = 0;
        while (error !== 1'b1 && waited < 30) begin
            cycle();
            waited++;
        end
        chk("t4_timeout_cycles", 32'(waited), 32'd10);
        chk("t4_errcode", 32'(err_code), 32'd2);
        chk("t4_rdwrb", 32'(rdwrb), 32'd1);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // Reset in the middle of WRITE, then a clean new transfer
        fill_random(2);
        do_start();
        send(2, -1, -1, 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = $urandom;
        resetn   = 1'b0;
        cycle();
        chk_reset_vals();
        resetn   = 1'b1;
        s_tvalid = 1'b0;
        cycle();
        chk("t5_no_write_after_reset", 32'(csib), 32'd1);
        chk("t5_drained", 32'(exp_q.size()), 32'd0);
        fill_random(2);
        do_start();
        send(2, -1, -1, 1'b1);
        pulse_prdone();
        chk("t5_wc", word_count, 32'd2);
        chk("t5_done", 32'(done), 32'd1);

        // Identity data path with BIT_SWAP=0; swapped instance holds its last word
        tx_q = '{32'h0, 32'hAA995566};
        tx_q[0] = $urandom;
        do_start();
        send(2, -1, -1, 1'b1);
        pulse_prdone();
        repeat (2) cycle();
        chk("t6_noswap_i", last_i0, 32'hAA995566);
        chk("t6_swap_i_held", i_w, 32'h5599AA66);
        chk("t6_noswap_done", 32'(done0), 32'd1);

        // PRDONE and PRERROR together: PRERROR wins
        fill_random(2);
        do_start();
        send(2, -1, -1, 1'b1);
        prdone  = 1'b1;
        prerror = 1'b1;
        cycle();
        prdone  = 1'b0;
        prerror = 1'b0;
        chk("t7_error", 32'(error), 32'd1);
        chk("t7_errcode", 32'(err_code), 32'd1);
        chk("t7_done", 32'(done), 32'd0);
        chk("t7_wc", word_count, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
